// File: rtl/reg_wb_stage_pkg.sv
// Shared types and encodings for the write-back stage: destination classes,
// bus widths and the FSM state encoding.
package reg_wb_stage_pkg;

  localparam int REG_OP_W   = 3;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  typedef enum logic [REG_OP_W-1:0] {
    REG_OP_NOP = 3'd0,
    REG_OP_REG = 3'd1,
    REG_OP_T   = 3'd2,
    REG_OP_SP  = 3'd3,
    REG_OP_IH  = 3'd4,
    REG_OP_RA  = 3'd5
  } reg_op_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam data_t DATA_ZERO = '0;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  function automatic logic is_write(input reg_op_e op);
    return op != REG_OP_NOP;
  endfunction

endpackage

// File: rtl/reg_wb_stage.sv
// Write-back stage: turns retiring MEM-stage results into single-cycle
// register-file writes, stalling the pipeline while a load is outstanding.
module reg_wb_stage
  import reg_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic      clk_50MHz,
  input  logic      rst,
  input  logic      in_valid,
  input  reg_op_e   in_reg_op,
  input  reg_addr_t in_wb_addr,
  input  data_t     in_alu_data,
  input  logic      in_is_load,
  input  data_t     mem_rdata,
  input  logic      mem_rvalid,
  input  logic      flush,
  output logic      in_ready,
  output reg_op_e   reg_op,
  output reg_addr_t wb_addr,
  output data_t     wb_data,
  output logic      ld_pending,
  output reg_op_e   ld_pending_op,
  output reg_addr_t ld_pending_addr,
  output logic [15:0] retire_cnt,
  output logic      ld_timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  wb_state_e        r_state;
  wb_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  reg_op_e          r_reg_op;
  reg_addr_t        r_wb_addr;
  data_t            r_wb_data;
  reg_op_e          r_ld_op;
  reg_addr_t        r_ld_addr;
  logic [15:0]      r_retire_cnt;
  logic             r_ld_timeout;

  logic             w_in_wait;
  logic             w_accept;
  logic             w_accept_now;
  logic             w_accept_wait;
  logic             w_ld_done;
  logic             w_ld_expire;

  assign w_in_wait     = (r_state == ST_WAIT_LOAD);
  assign w_accept      = (r_state == ST_IDLE) && in_valid && !flush;
  assign w_accept_now  = w_accept && (!in_is_load || mem_rvalid);
  assign w_accept_wait = w_accept && in_is_load && !mem_rvalid;

  // Flush takes priority over load data arriving in the same cycle.
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_ld_done   = w_in_wait && !flush && mem_rvalid;
  assign w_ld_expire = w_in_wait && !flush && !mem_rvalid &&
                       (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_wait) begin
          w_state_nxt = ST_WAIT_LOAD;
        end
      end
      ST_WAIT_LOAD: begin
        if (flush || mem_rvalid || w_ld_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready        = (r_state == ST_IDLE);
    ld_pending      = w_in_wait;
    ld_pending_op   = REG_OP_NOP;
    ld_pending_addr = '0;
    if (w_in_wait) begin
      ld_pending_op   = r_ld_op;
      ld_pending_addr = r_ld_addr;
    end
  end

  // Write port: reg_op pulses for one cycle, address/data hold between writes.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_reg_op  <= REG_OP_NOP;
      r_wb_addr <= '0;
      r_wb_data <= DATA_ZERO;
    end else begin
      r_reg_op <= REG_OP_NOP;
      if (w_accept_now) begin
        r_reg_op <= in_reg_op;
        if (is_write(in_reg_op)) begin
          r_wb_addr <= in_wb_addr;
          r_wb_data <= in_is_load ? mem_rdata : in_alu_data;
        end
      end else if (w_ld_done) begin
        r_reg_op <= r_ld_op;
        if (is_write(r_ld_op)) begin
          r_wb_addr <= r_ld_addr;
          r_wb_data <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_ld_op   <= REG_OP_NOP;
      r_ld_addr <= '0;
      r_cnt     <= '0;
    end else if (w_accept_wait) begin
      r_ld_op   <= in_reg_op;
      r_ld_addr <= in_wb_addr;
      r_cnt     <= '0;
    end else if (w_in_wait) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
      r_ld_timeout <= 1'b0;
    end else begin
      if (is_write(r_reg_op)) begin
        r_retire_cnt <= r_retire_cnt + 16'd1;
      end
      if (w_ld_expire) begin
        r_ld_timeout <= 1'b1;
      end
    end
  end

  assign reg_op     = r_reg_op;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign retire_cnt = r_retire_cnt;
  assign ld_timeout = r_ld_timeout;

endmodule

// File: doc/reg_wb_stage.md
# reg_wb_stage

Write-back stage that produces the register-file write port: latches results leaving the memory stage, waits for load data, and issues exactly one single-cycle write (`reg_op`, `wb_addr`, `wb_data`) per retired instruction. Sits between the MEM stage / data-memory interface and the register file. Back-pressures the pipeline while a load is outstanding and exposes its pending destination to the hazard unit.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles spent in WAIT_LOAD before abandoning the load.

Ports:
- `clk_50MHz`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  MEM stage presents an instruction this cycle.
- `in_reg_op`  in  `REG_OP_BUS`  destination class: NOP, REG, T, SP, IH or RA.
- `in_wb_addr`  in  `REG_ADDR_BUS` (3)  general-register index; used only when `in_reg_op`=REG.
- `in_alu_data`  in  `DATA_BUS` (16)  ALU/PC result.
- `in_is_load`  in  1  result comes from `mem_rdata`, not `in_alu_data`.
- `mem_rdata`  in  16  load data.
- `mem_rvalid`  in  1  `mem_rdata` valid this cycle.
- `flush`  in  1  discard the instruction being accepted or waited on.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `reg_op`  out  `REG_OP_BUS`  register-file write command.
- `wb_addr`  out  3  register-file write index.
- `wb_data`  out  16  register-file write data.
- `ld_pending`  out  1  a load is outstanding.
- `ld_pending_op`, `ld_pending_addr`  out  `REG_OP_BUS`, 3  destination of the outstanding load.
- `retire_cnt`  out  16  count of issued non-NOP writes.
- `ld_timeout`  out  1  sticky: a load was abandoned by timeout.

## Operation
- States: IDLE, WAIT_LOAD.
- `in_ready` = (state == IDLE), combinational.
- **IDLE, accepting** (`in_valid` && !`flush`):
  - `in_is_load`=0: next cycle drive `reg_op`=`in_reg_op`, `wb_addr`=`in_wb_addr`, `wb_data`=`in_alu_data`.
  - `in_is_load`=1 and `mem_rvalid`=1 in the same cycle: same as above, with `wb_data`=`mem_rdata`.
  - `in_is_load`=1 and `mem_rvalid`=0: latch op/addr, clear the timeout counter, go to WAIT_LOAD.
- **IDLE, dropping:**
  - `in_valid` && `flush`: the instruction is dropped; `reg_op`=NOP next cycle.
  - `mem_rvalid` without an accepted load is ignored.
- **WAIT_LOAD:**
  - `ld_pending`=1; `ld_pending_op` and `ld_pending_addr` hold the latched destination.
  - `mem_rvalid`: next cycle issue the write with `mem_rdata`; go to IDLE.
  - `flush`: abandon, no write; go to IDLE. Flush wins over a simultaneous `mem_rvalid`.
  - Counter reaches `TIMEOUT` with no `mem_rvalid`: abandon, set `ld_timeout`; go to IDLE.
- `reg_op` is NOP in every cycle except the single write cycle. `wb_addr` and `wb_data` hold their last values when `reg_op` is NOP.
- An accepted instruction with `in_reg_op`=NOP produces no write and is not counted.
- `retire_cnt` increments on each cycle where `reg_op` is not NOP; it wraps 0xFFFF→0x0000.
- `ld_timeout` clears only on reset.

## Timing
- Reset values: state IDLE; `reg_op`=NOP; `wb_addr`=0; `wb_data`=0x0000; `ld_pending`=0; `ld_pending_op`=NOP; `ld_pending_addr`=0; `retire_cnt`=0; `ld_timeout`=0. `in_ready`=1 after reset.
- ALU result or same-cycle load: write visible exactly 1 cycle after acceptance.
- Delayed load: write visible 1 cycle after the `mem_rvalid` cycle.
- `ld_pending` rises the cycle after acceptance and falls in the write cycle.
- Back-to-back non-load instructions: one write per cycle, no bubbles.
- Reset asserted mid-WAIT_LOAD: immediate return to reset values; no write is ever issued for that load.

## Structure
- `REG_OP_*` codes, `REG_OP_BUS`, `REG_ADDR_BUS`, `DATA_BUS`, `DATA_ZERO` and the state encodings belong in the shared `define.v`.
- Single module, no sub-module; the timeout counter is inline, with width `$clog2(TIMEOUT+1)`.

## Test plan
- ALU write: `in_valid`=1, op=REG, addr=5, alu=0x1234 → next cycle `reg_op`=REG, `wb_addr`=5, `wb_data`=0x1234; following cycle `reg_op`=NOP; `retire_cnt`=1.
- Delayed load: op=SP, `in_is_load`=1, `mem_rdata` 0xBEEF arriving 3 cycles later → `in_ready`=0 and `ld_pending`=1 for 3 cycles; write SP=0xBEEF one cycle after `mem_rvalid`.
- Flush: flush during WAIT_LOAD coinciding with `mem_rvalid` → no write, state IDLE, `retire_cnt` unchanged.
- Timeout: load accepted, no `mem_rvalid` for 15 cycles → `ld_timeout`=1, `in_ready`=1, no write issued.
- Streaming and wrap: 4 consecutive ALU ops to T, IH, RA, REG 7 → 4 consecutive write cycles; with `retire_cnt` preset to 0xFFFF by prior traffic, the next write gives 0x0000.
- Reset mid-load: `rst` low during WAIT_LOAD → all outputs at reset values immediately; a later `mem_rvalid` produces no write.
